// File: rtl/disp_scan_mux_pkg.sv
// disp_scan_mux_pkg
// Shared constants and elaboration-time helpers for the 7-segment scan
// multiplexer (disp_scan_mux) and its slot timer.
//   NIB_W         : width of one displayed hex digit
//   AN_OFF/DP_OFF : inactive levels of the active-low anode and dp drives
//   params_legal  : parameter legality test used at elaboration
//   idx_w         : index width for a count of n items (never below 1)
package disp_scan_mux_pkg;

    localparam int   NIB_W  = 4;
    localparam logic AN_OFF = 1'b1;
    localparam logic DP_OFF = 1'b1;

    function automatic bit params_legal(input int n_dig,
                                        input int refresh_div,
                                        input int blank_cyc);
        return (n_dig >= 1) && (n_dig <= 8) &&
               (refresh_div >= 2) &&
               (blank_cyc >= 0) && (blank_cyc < refresh_div);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_scan_mux_scan_timer.sv
// disp_scan_mux_scan_timer
// Slot timer for the display scan. A divider counts REFRESH_DIV cycles per
// digit slot; each divider wrap advances the slot, wrapping after the last
// digit.
//   clk_i       : system clock, rising edge
//   rst_i       : asynchronous active-high reset
//   slot_o      : digit currently being scanned
//   in_guard_o  : 1 during the first BLANK_CYC cycles of a slot
//   boundary_o  : 1 on the last cycle of the last slot (end of frame)
module disp_scan_mux_scan_timer
    import disp_scan_mux_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int SLOT_W      = idx_w(N_DIG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              in_guard_o,
    output logic              boundary_o
);

    localparam int CNT_W = idx_w(REFRESH_DIV);

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  GUARD_END = CNT_W'(BLANK_CYC);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_DIG - 1);

    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              div_wrap_s;

    // Next-state for the divider and the slot index.
    always_comb begin
        div_wrap_s = (div_cnt_q == DIV_LAST);
        div_cnt_d  = div_cnt_q;
        slot_d     = slot_q;
        if (div_wrap_s) begin
            div_cnt_d = {CNT_W{1'b0}};
            if (slot_q == SLOT_LAST) begin
                slot_d = {SLOT_W{1'b0}};
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
            slot_d    = slot_q;
        end
    end

    // Divider and slot registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= {CNT_W{1'b0}};
            slot_q    <= {SLOT_W{1'b0}};
        end else begin
            div_cnt_q <= div_cnt_d;
            slot_q    <= slot_d;
        end
    end

    assign slot_o     = slot_q;
    assign in_guard_o = (div_cnt_q < GUARD_END);
    assign boundary_o = div_wrap_s && (slot_q == SLOT_LAST);

endmodule

// File: rtl/disp_scan_mux.sv
// disp_scan_mux
// Time-multiplexed scan controller for an N_DIG-digit common-anode 7-segment
// display. A double-buffered value (pending -> display at each frame end)
// is scanned one digit per slot; each slot starts with a blank guard to
// avoid ghosting, and leading zeros can be suppressed. All outputs are
// registered and lag the scan state by one cycle.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   load_i           : one-cycle strobe capturing data_in_i/dp_in_i
//   data_in_i        : nibble i = digit i, digit 0 rightmost
//   dp_in_i          : per-digit decimal point request, 1 = lit
//   lz_blank_en_i    : 1 = suppress leading zeros
//   dig_o            : nibble of the scanned digit, to the segment decoder
//   an_o             : active-low anode enables, one-hot-low or all high
//   dp_o             : active-low decimal point segment
//   frame_tick_o     : one-cycle pulse on the cycle after each frame end
module disp_scan_mux
    import disp_scan_mux_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [NIB_W*N_DIG-1:0] data_in_i,
    input  logic [N_DIG-1:0]       dp_in_i,
    input  logic                   lz_blank_en_i,
    output logic [NIB_W-1:0]       dig_o,
    output logic [N_DIG-1:0]       an_o,
    output logic                   dp_o,
    output logic                   frame_tick_o
);

    localparam int DW     = NIB_W * N_DIG;
    localparam int SLOT_W = idx_w(N_DIG);

    if (!params_legal(N_DIG, REFRESH_DIV, BLANK_CYC)) begin : g_bad_params
        $error("disp_scan_mux: need 1<=N_DIG<=8, REFRESH_DIV>=2, 0<=BLANK_CYC<REFRESH_DIV");
    end

    logic [SLOT_W-1:0] slot_s;
    logic              in_guard_s;
    logic              boundary_s;

    disp_scan_mux_scan_timer #(
        .N_DIG       (N_DIG),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .SLOT_W      (SLOT_W)
    ) u_scan_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .slot_o     (slot_s),
        .in_guard_o (in_guard_s),
        .boundary_o (boundary_s)
    );

    logic [DW-1:0]    pend_data_q, pend_data_d;
    logic [N_DIG-1:0] pend_dp_q, pend_dp_d;
    logic [DW-1:0]    disp_data_q, disp_data_d;
    logic [N_DIG-1:0] disp_dp_q, disp_dp_d;

    logic [NIB_W-1:0] nib_s [N_DIG];
    logic [N_DIG-1:0] blank_s;
    logic             lit_s;

    logic [NIB_W-1:0] dig_q, dig_d;
    logic [N_DIG-1:0] an_q, an_d;
    logic             dp_q, dp_d;
    logic             frame_tick_q, frame_tick_d;

    // Digit i is a leading zero when it and every more-significant nibble
    // are zero; digit 0 always shows so a zero value is still visible.
    for (genvar g = 0; g < N_DIG; g++) begin : g_digit
        assign nib_s[g] = disp_data_q[g*NIB_W +: NIB_W];
        if (g == 0) begin : g_lsd
            assign blank_s[g] = 1'b0;
        end else begin : g_upper
            assign blank_s[g] = lz_blank_en_i &
                                ~(|disp_data_q[DW-1:g*NIB_W]);
        end
    end

    // Pending capture and frame-synchronous transfer to the display buffer.
    // A load on the frame-end cycle goes straight to the display so it is
    // not delayed a whole frame.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        if (load_i) begin
            pend_data_d = data_in_i;
            pend_dp_d   = dp_in_i;
        end else begin
            pend_data_d = pend_data_q;
            pend_dp_d   = pend_dp_q;
        end
        if (boundary_s) begin
            if (load_i) begin
                disp_data_d = data_in_i;
                disp_dp_d   = dp_in_i;
            end else begin
                disp_data_d = pend_data_q;
                disp_dp_d   = pend_dp_q;
            end
        end else begin
            disp_data_d = disp_data_q;
            disp_dp_d   = disp_dp_q;
        end
    end

    // Pending and display buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_data_q <= {DW{1'b0}};
            pend_dp_q   <= {N_DIG{1'b0}};
            disp_data_q <= {DW{1'b0}};
            disp_dp_q   <= {N_DIG{1'b0}};
        end else begin
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
        end
    end

    // Output decode for the current slot; only one anode can ever be driven.
    always_comb begin
        lit_s        = ~in_guard_s & ~blank_s[slot_s];
        dig_d        = nib_s[slot_s];
        an_d         = {N_DIG{AN_OFF}};
        dp_d         = DP_OFF;
        frame_tick_d = boundary_s;
        if (lit_s) begin
            an_d[slot_s] = ~AN_OFF;
            dp_d         = ~disp_dp_q[slot_s];
        end else begin
            an_d = {N_DIG{AN_OFF}};
            dp_d = DP_OFF;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dig_q        <= {NIB_W{1'b0}};
            an_q         <= {N_DIG{AN_OFF}};
            dp_q         <= DP_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            dig_q        <= dig_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign dig_o        = dig_q;
    assign an_o         = an_q;
    assign dp_o         = dp_q;
    assign frame_tick_o = frame_tick_q;

endmodule
